// File: rtl/vx_warp_issue_sched_pkg.sv
// Shared types and constants for the warp issue scheduler.
// Holds the resolution request bundles and the warp-id width helper.
package vx_warp_issue_sched_pkg;

  localparam int DEF_NUM_WARPS   = 4;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_PC_BITS     = 30;
  localparam int PC_INC          = 2;

  function automatic int nw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NW_WIDTH = nw_width(DEF_NUM_WARPS);

  typedef struct packed {
    logic                   valid;
    logic [NW_WIDTH-1:0]    wid;
    logic                   taken;
    logic [DEF_PC_BITS-1:0] target;
  } br_req_t;

  typedef struct packed {
    logic                       valid;
    logic [NW_WIDTH-1:0]        wid;
    logic [DEF_NUM_THREADS-1:0] mask;
  } tmc_req_t;

  typedef struct packed {
    logic                     valid;
    logic [NW_WIDTH-1:0]      wid;
    logic [DEF_NUM_WARPS-1:0] mask;
    logic [DEF_PC_BITS-1:0]   pc;
  } wspawn_req_t;

endpackage

// File: rtl/vx_warp_issue_sched_if.sv
// Issue handshake between the warp scheduler and fetch.
// Master is the scheduler; slave is the fetch unit.
interface vx_warp_issue_sched_if #(
  parameter int NUM_THREADS = vx_warp_issue_sched_pkg::DEF_NUM_THREADS,
  parameter int PC_BITS     = vx_warp_issue_sched_pkg::DEF_PC_BITS,
  parameter int NW_WIDTH    = vx_warp_issue_sched_pkg::NW_WIDTH
);
  logic                   valid;
  logic                   ready;
  logic [NW_WIDTH-1:0]    wid;
  logic [PC_BITS-1:0]     pc;
  logic [NUM_THREADS-1:0] tmask;
  logic                   stall;

  modport master (
    output valid, wid, pc, tmask,
    input  ready, stall
  );

  modport slave (
    input  valid, wid, pc, tmask,
    output ready, stall
  );
endinterface

// File: rtl/vx_warp_rr_arb.sv
// Rotate-priority picker: first ready warp at or after rr_ptr.
// Purely combinational so other schedulers can reuse it.
module vx_warp_rr_arb #(
  parameter int N = vx_warp_issue_sched_pkg::DEF_NUM_WARPS,
  parameter int W = vx_warp_issue_sched_pkg::nw_width(N)
) (
  input  logic [N-1:0] ready,
  input  logic [W-1:0] rr_ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);
  int idx;

  // scan from rr_ptr, wrapping, keep the first hit
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!grant_valid && ready[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = W'(idx);
      end
    end
  end
endmodule

// File: rtl/vx_warp_issue_sched.sv
// Per-core warp scheduler: owns warp state, issues round-robin to fetch.
// Optional SCHED_PERF_EN adds saturating idle/stall cycle counters.
module vx_warp_issue_sched #(
  parameter int NUM_WARPS   = vx_warp_issue_sched_pkg::DEF_NUM_WARPS,
  parameter int NUM_THREADS = vx_warp_issue_sched_pkg::DEF_NUM_THREADS,
  parameter int PC_BITS     = vx_warp_issue_sched_pkg::DEF_PC_BITS,
  parameter int PC_INC      = vx_warp_issue_sched_pkg::PC_INC,
  parameter int NW_WIDTH    = vx_warp_issue_sched_pkg::nw_width(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_valid,
  input  logic [PC_BITS-1:0]             start_pc,
  vx_warp_issue_sched_if.master          issue_if,
  input  logic                           br_valid,
  input  logic [NW_WIDTH-1:0]            br_wid,
  input  logic                           br_taken,
  input  logic [PC_BITS-1:0]             br_target,
  input  logic                           tmc_valid,
  input  logic [NW_WIDTH-1:0]            tmc_wid,
  input  logic [NUM_THREADS-1:0]         tmc_mask,
  input  logic                           wspawn_valid,
  input  logic [NW_WIDTH-1:0]            wspawn_wid,
  input  logic [NUM_WARPS-1:0]           wspawn_mask,
  input  logic [PC_BITS-1:0]             wspawn_pc,
  output logic [NUM_WARPS-1:0]           active_warps,
  output logic [NUM_WARPS-1:0]           stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic [NUM_WARPS*PC_BITS-1:0]   warp_pcs,
`ifdef SCHED_PERF_EN
  output logic [31:0]                    perf_idle_cycles,
  output logic [31:0]                    perf_stall_cycles,
`endif
  output logic                           sched_busy
);
  import vx_warp_issue_sched_pkg::*;

  logic [NUM_WARPS-1:0]   active;
  logic [NUM_WARPS-1:0]   stalled;
  logic [NUM_THREADS-1:0] tmask [NUM_WARPS];
  logic [PC_BITS-1:0]     pc    [NUM_WARPS];
  logic [NW_WIDTH-1:0]    rr_ptr;
  logic [NUM_WARPS-1:0]   ready;
  logic                   grant_valid;
  logic [NW_WIDTH-1:0]    grant_idx;
  logic                   fire;
  br_req_t                br;
  tmc_req_t               tmc;
  wspawn_req_t            ws;

  assign br  = '{valid: br_valid, wid: br_wid,
                 taken: br_taken, target: br_target};
  assign tmc = '{valid: tmc_valid, wid: tmc_wid, mask: tmc_mask};
  assign ws  = '{valid: wspawn_valid, wid: wspawn_wid,
                 mask: wspawn_mask, pc: wspawn_pc};

  assign ready = active & ~stalled;

  vx_warp_rr_arb #(.N(NUM_WARPS), .W(NW_WIDTH)) u_arb (
    .ready       (ready),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign fire           = grant_valid & issue_if.ready;
  assign issue_if.valid = grant_valid;
  assign issue_if.wid   = grant_idx;
  assign issue_if.pc    = pc[grant_idx];
  assign issue_if.tmask = tmask[grant_idx];

  assign active_warps  = active;
  assign stalled_warps = stalled;
  assign sched_busy    = |active;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_flat
    assign thread_masks[w*NUM_THREADS +: NUM_THREADS] = tmask[w];
    assign warp_pcs[w*PC_BITS +: PC_BITS]             = pc[w];
  end

  // warp state: issue advance, launch, then resolutions; spawn applied last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= '0;
      stalled <= '0;
      rr_ptr  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        tmask[w] <= '0;
        pc[w]    <= '0;
      end
    end else begin
      if (fire) begin
        pc[grant_idx] <= pc[grant_idx] + PC_BITS'(PC_INC);
        rr_ptr <= (grant_idx == NW_WIDTH'(NUM_WARPS-1))
                ? '0 : grant_idx + 1'b1;
        if (issue_if.stall)
          stalled[grant_idx] <= 1'b1;
      end
      if (start_valid && !sched_busy) begin
        active[0]  <= 1'b1;
        tmask[0]   <= '1;
        pc[0]      <= start_pc;
        stalled[0] <= 1'b0;
      end
      if (br.valid) begin
        if (br.taken)
          pc[br.wid] <= br.target;
        stalled[br.wid] <= 1'b0;
      end
      if (tmc.valid) begin
        tmask[tmc.wid]   <= tmc.mask;
        stalled[tmc.wid] <= 1'b0;
        if (tmc.mask == '0)
          active[tmc.wid] <= 1'b0;
      end
      if (ws.valid) begin
        stalled[ws.wid] <= 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
          if (ws.mask[w] && !active[w]) begin
            active[w]  <= 1'b1;
            tmask[w]   <= '1;
            pc[w]      <= ws.pc;
            stalled[w] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SCHED_PERF_EN
  // saturating idle and backpressure cycle counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_idle_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (sched_busy && !grant_valid && perf_idle_cycles != '1)
        perf_idle_cycles <= perf_idle_cycles + 32'd1;
      if (grant_valid && !issue_if.ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_warp_issue_sched.sv
// Bench for vx_warp_issue_sched: directed scenarios plus random
// traffic against a warp-level reference model.
module tb_vx_warp_issue_sched;
  localparam int NW = 4;
  localparam int NT = 4;
  localparam int PB = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start_valid;
  logic [PB-1:0] start_pc;
  logic          br_valid, br_taken;
  logic [1:0]    br_wid;
  logic [PB-1:0] br_target;
  logic          tmc_valid;
  logic [1:0]    tmc_wid;
  logic [NT-1:0] tmc_mask;
  logic          wspawn_valid;
  logic [1:0]    wspawn_wid;
  logic [NW-1:0] wspawn_mask;
  logic [PB-1:0] wspawn_pc;
  logic [NW-1:0] active_warps, stalled_warps;
  logic [NW*NT-1:0] thread_masks;
  logic [NW*PB-1:0] warp_pcs;
  logic          sched_busy;
`ifdef SCHED_PERF_EN
  logic [31:0]   perf_idle, perf_stall;
`endif

  vx_warp_issue_sched_if #(.NUM_THREADS(NT), .PC_BITS(PB),
                           .NW_WIDTH(2)) ifc ();

  vx_warp_issue_sched dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_pc      (start_pc),
    .issue_if      (ifc),
    .br_valid      (br_valid),
    .br_wid        (br_wid),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .tmc_valid     (tmc_valid),
    .tmc_wid       (tmc_wid),
    .tmc_mask      (tmc_mask),
    .wspawn_valid  (wspawn_valid),
    .wspawn_wid    (wspawn_wid),
    .wspawn_mask   (wspawn_mask),
    .wspawn_pc     (wspawn_pc),
    .active_warps  (active_warps),
    .stalled_warps (stalled_warps),
    .thread_masks  (thread_masks),
    .warp_pcs      (warp_pcs),
`ifdef SCHED_PERF_EN
    .perf_idle_cycles  (perf_idle),
    .perf_stall_cycles (perf_stall),
`endif
    .sched_busy    (sched_busy)
  );

  int total = 0;
  int bad = 0;

  bit [NW-1:0] m_act, m_stl;
  bit [NT-1:0] m_msk [NW];
  bit [PB-1:0] m_pc  [NW];
  int          m_rr;
  int          m_idle, m_bp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_sel();
    for (int k = 0; k < NW; k++) begin
      int w = (m_rr + k) % NW;
      if (m_act[w] && !m_stl[w]) return w;
    end
    return -1;
  endfunction

  function automatic int pick_stalled();
    int c[$];
    for (int w = 0; w < NW; w++)
      if (m_stl[w]) c.push_back(w);
    if (c.size() == 0) return -1;
    return c[$urandom % c.size()];
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if (ifc.valid !== 1'b0 || sched_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_issue: valid=%b busy=%b want 0 0",
               ifc.valid, sched_busy);
    end
    total++;
    if (active_warps !== 0 || stalled_warps !== 0 ||
        warp_pcs !== 0 || thread_masks !== 0) begin
      bad++;
      $display("FAIL reset_state: act=%b stl=%b want all 0",
               active_warps, stalled_warps);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_launch();
    @(negedge clk);
    start_valid = 1'b1;
    start_pc = 'h100;
    ifc.ready = 1'b1;
    step();
    start_valid = 1'b0;
    total++;
    if (ifc.valid !== 1'b1 || ifc.wid !== 2'd0 ||
        ifc.pc !== 'h100 || ifc.tmask !== 4'hF) begin
      bad++;
      $display("FAIL launch_c1: v=%b wid=%0d pc=%h tm=%h want 1 0 100 f",
               ifc.valid, ifc.wid, ifc.pc, ifc.tmask);
    end
    total++;
    if (active_warps !== 4'b0001) begin
      bad++;
      $display("FAIL launch_act: got %b want 0001", active_warps);
    end
    step();
    total++;
    if (ifc.pc !== 'h102) begin
      bad++;
      $display("FAIL launch_c2: pc=%h want 102", ifc.pc);
    end
  endtask

  task automatic test_branch();
    ifc.stall = 1'b1;
    step();
    ifc.stall = 1'b0;
    total++;
    if (ifc.valid !== 1'b0 || stalled_warps !== 4'b0001 ||
        warp_pcs[PB-1:0] !== 'h104) begin
      bad++;
      $display("FAIL br_stall: v=%b stl=%b pc0=%h want 0 0001 104",
               ifc.valid, stalled_warps, warp_pcs[PB-1:0]);
    end
    br_valid = 1'b1;
    br_wid = 2'd0;
    br_taken = 1'b1;
    br_target = 'h200;
    step();
    br_valid = 1'b0;
    total++;
    if (ifc.valid !== 1'b1 || ifc.pc !== 'h200 ||
        stalled_warps !== 4'b0000) begin
      bad++;
      $display("FAIL br_taken: v=%b pc=%h stl=%b want 1 200 0000",
               ifc.valid, ifc.pc, stalled_warps);
    end
  endtask

  task automatic test_wspawn();
    int ew [4] = '{1, 2, 3, 0};
    int ep [4] = '{'h300, 'h300, 'h300, 'h200};
    ifc.ready = 1'b0;
    wspawn_valid = 1'b1;
    wspawn_wid = 2'd0;
    wspawn_mask = 4'b1110;
    wspawn_pc = 'h300;
    step();
    wspawn_valid = 1'b0;
    total++;
    if (active_warps !== 4'b1111) begin
      bad++;
      $display("FAIL ws_act: got %b want 1111", active_warps);
    end
    ifc.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ifc.wid !== 2'(ew[i]) || ifc.pc !== PB'(ep[i])) begin
        bad++;
        $display("FAIL ws_order%0d: wid=%0d pc=%h want %0d %h",
                 i, ifc.wid, ifc.pc, ew[i], ep[i]);
      end
      step();
    end
  endtask

  task automatic test_tmc();
    ifc.ready = 1'b0;
    tmc_valid = 1'b1;
    tmc_wid = 2'd2;
    tmc_mask = 4'h3;
    step();
    total++;
    if (thread_masks[11:8] !== 4'h3 || active_warps !== 4'b1111) begin
      bad++;
      $display("FAIL tmc_mask: tm2=%h act=%b want 3 1111",
               thread_masks[11:8], active_warps);
    end
    tmc_wid = 2'd0;
    tmc_mask = 4'h0;
    step();
    total++;
    if (active_warps !== 4'b1110) begin
      bad++;
      $display("FAIL tmc_kill0: act=%b want 1110", active_warps);
    end
    for (int w = 1; w < NW; w++) begin
      tmc_wid = 2'(w);
      step();
    end
    tmc_valid = 1'b0;
    total++;
    if (sched_busy !== 1'b0 || ifc.valid !== 1'b0 ||
        active_warps !== 0) begin
      bad++;
      $display("FAIL tmc_idle: busy=%b v=%b act=%b want 0 0 0000",
               sched_busy, ifc.valid, active_warps);
    end
  endtask

  task automatic test_async_reset();
    start_valid = 1'b1;
    start_pc = 'h500;
    ifc.ready = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    total++;
    if (ifc.valid !== 1'b1 || ifc.pc !== 'h502) begin
      bad++;
      $display("FAIL rst_pre: v=%b pc=%h want 1 502",
               ifc.valid, ifc.pc);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (ifc.valid !== 1'b0 || sched_busy !== 1'b0 ||
        active_warps !== 0 || warp_pcs !== 0) begin
      bad++;
      $display("FAIL rst_async: v=%b busy=%b act=%b want 0 0 0",
               ifc.valid, sched_busy, active_warps);
    end
`ifdef SCHED_PERF_EN
    total++;
    if (perf_idle !== 0 || perf_stall !== 0) begin
      bad++;
      $display("FAIL rst_perf: idle=%0d stall=%0d want 0 0",
               perf_idle, perf_stall);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_backpressure();
    ifc.ready = 1'b0;
    start_valid = 1'b1;
    start_pc = 'h40;
    step();
    start_valid = 1'b0;
    repeat (5) step();
    total++;
    if (ifc.valid !== 1'b1 || ifc.wid !== 2'd0 || ifc.pc !== 'h40) begin
      bad++;
      $display("FAIL bp_hold: v=%b wid=%0d pc=%h want 1 0 40",
               ifc.valid, ifc.wid, ifc.pc);
    end
`ifdef SCHED_PERF_EN
    total++;
    if (perf_stall !== 32'd5 || perf_idle !== 32'd0) begin
      bad++;
      $display("FAIL bp_perf: stall=%0d idle=%0d want 5 0",
               perf_stall, perf_idle);
    end
`endif
    ifc.ready = 1'b1;
    step();
    ifc.ready = 1'b0;
    total++;
    if (ifc.pc !== 'h42) begin
      bad++;
      $display("FAIL bp_release: pc=%h want 42", ifc.pc);
    end
  endtask

  task automatic test_random();
    logic [NW*NT-1:0] e_tm;
    logic [NW*PB-1:0] e_pc;
    bit [NW-1:0] old_act;
    int s, t;
    bit busy_old;
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_act = '0;
    m_stl = '0;
    m_rr = 0;
    m_idle = 0;
    m_bp = 0;
    for (int w = 0; w < NW; w++) begin
      m_msk[w] = '0;
      m_pc[w] = '0;
    end
    step();
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = m_sel();
      for (int w = 0; w < NW; w++) begin
        e_tm[w*NT +: NT] = m_msk[w];
        e_pc[w*PB +: PB] = m_pc[w];
      end
      total++;
      if (ifc.valid !== (s >= 0) ||
          (s >= 0 && (ifc.wid !== 2'(s) || ifc.pc !== m_pc[s] ||
                      ifc.tmask !== m_msk[s]))) begin
        bad++;
        $display("FAIL rnd_issue c%0d: v=%b wid=%0d pc=%h want sel=%0d",
                 cyc, ifc.valid, ifc.wid, ifc.pc, s);
      end
      total++;
      if (active_warps !== m_act || stalled_warps !== m_stl ||
          thread_masks !== e_tm || warp_pcs !== e_pc ||
          sched_busy !== (|m_act)) begin
        bad++;
        $display("FAIL rnd_state c%0d: act=%b stl=%b want %b %b",
                 cyc, active_warps, stalled_warps, m_act, m_stl);
      end
`ifdef SCHED_PERF_EN
      total++;
      if (perf_idle !== 32'(m_idle) || perf_stall !== 32'(m_bp)) begin
        bad++;
        $display("FAIL rnd_perf c%0d: idle=%0d stall=%0d want %0d %0d",
                 cyc, perf_idle, perf_stall, m_idle, m_bp);
      end
`endif
      ifc.ready = ($urandom % 4) != 0;
      ifc.stall = ($urandom % 3) == 0;
      start_valid = ($urandom % 4) == 0;
      start_pc = PB'($urandom);
      t = pick_stalled();
      br_valid = (t >= 0) && ($urandom % 2 == 0);
      br_wid = 2'(t);
      br_taken = $urandom % 2;
      br_target = PB'($urandom);
      t = pick_stalled();
      tmc_valid = (t >= 0) && ($urandom % 4 == 0);
      tmc_wid = 2'(t);
      tmc_mask = ($urandom % 5 == 0) ? 4'h0 : NT'($urandom);
      t = pick_stalled();
      wspawn_valid = (t >= 0) && ($urandom % 5 == 0);
      wspawn_wid = 2'(t);
      wspawn_mask = NW'($urandom);
      wspawn_pc = PB'($urandom);

      old_act = m_act;
      busy_old = |m_act;
      if (busy_old && s < 0) m_idle++;
      if (s >= 0 && !ifc.ready) m_bp++;
      if (s >= 0 && ifc.ready) begin
        m_pc[s] = m_pc[s] + PB'(2);
        m_rr = (s + 1) % NW;
        if (ifc.stall) m_stl[s] = 1'b1;
      end
      if (start_valid && !busy_old) begin
        m_act[0] = 1'b1;
        m_msk[0] = '1;
        m_pc[0] = start_pc;
        m_stl[0] = 1'b0;
      end
      if (br_valid) begin
        if (br_taken) m_pc[br_wid] = br_target;
        m_stl[br_wid] = 1'b0;
      end
      if (tmc_valid) begin
        m_msk[tmc_wid] = tmc_mask;
        m_stl[tmc_wid] = 1'b0;
        if (tmc_mask == 0) m_act[tmc_wid] = 1'b0;
      end
      if (wspawn_valid) begin
        m_stl[wspawn_wid] = 1'b0;
        for (int w = 0; w < NW; w++) begin
          if (wspawn_mask[w] && !old_act[w]) begin
            m_act[w] = 1'b1;
            m_msk[w] = '1;
            m_pc[w] = wspawn_pc;
            m_stl[w] = 1'b0;
          end
        end
      end
      step();
    end
    start_valid = 1'b0;
    br_valid = 1'b0;
    tmc_valid = 1'b0;
    wspawn_valid = 1'b0;
  endtask

  initial begin
    start_valid = 1'b0;
    start_pc = '0;
    br_valid = 1'b0;
    br_wid = '0;
    br_taken = 1'b0;
    br_target = '0;
    tmc_valid = 1'b0;
    tmc_wid = '0;
    tmc_mask = '0;
    wspawn_valid = 1'b0;
    wspawn_wid = '0;
    wspawn_mask = '0;
    wspawn_pc = '0;
    ifc.ready = 1'b0;
    ifc.stall = 1'b0;
    test_reset();
    test_launch();
    test_branch();
    test_wspawn();
    test_tmc();
    test_async_reset();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
